// File: rtl/konami_cs_sequencer_if.sv
// CPU-side access bus for the chip-select sequencer: latched address, strobe and remap in,
// one-hot active-low selects plus READY/NOMATCH/BUSY status back to the bus glue.
interface konami_cs_sequencer_if #(
  parameter int ADDR_W = 16,
  parameter int N_CS   = 4
);
  logic [ADDR_W-1:0] ADDR;
  logic              AS;
  logic              RMRD;
  logic [N_CS-1:0]   CS_N;
  logic              READY;
  logic              NOMATCH;
  logic              BUSY;

  modport master (
    output ADDR, AS, RMRD,
    input  CS_N, READY, NOMATCH, BUSY
  );

  modport slave (
    input  ADDR, AS, RMRD,
    output CS_N, READY, NOMATCH, BUSY
  );
endinterface

// File: rtl/konami_cs_sequencer.sv
// Registered chip-select decoder with fixed-priority regions, RMRD remap, per-region wait
// states and a READY handshake held until the CPU drops its access strobe.
module konami_cs_sequencer #(
  parameter int                 ADDR_W   = 16,
  parameter int                 N_CS     = 4,
  parameter logic [N_CS*ADDR_W-1:0] BASE = {16'h4000, 16'h5F80, 16'h0400, 16'h0000},
  parameter logic [N_CS*ADDR_W-1:0] MASK = {16'hC000, 16'hFF80, 16'hFC00, 16'hFC00},
  parameter logic [N_CS*4-1:0]  WAIT     = {4'd3, 4'd2, 4'd1, 4'd0},
  parameter int                 RMRD_CS  = 3,
  parameter int                 RMRD_ALT = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  konami_cs_sequencer_if.slave  bus
);

  localparam int IDX_W = (N_CS > 1) ? $clog2(N_CS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_CS-1:0]   cs_n_q, cs_n_d;
  logic              ready_q, ready_d;
  logic              nomatch_q, nomatch_d;
  logic              busy_q, busy_d;
  logic [3:0]        cnt_q, cnt_d;

  logic [N_CS-1:0]   hit;
  logic [3:0]        wait_tbl [N_CS];
  logic              any_hit;
  logic [IDX_W-1:0]  winner;
  logic [3:0]        win_wait;
  logic [N_CS-1:0]   win_cs_n;

  // Per-region address compare and wait-state lookup table.
  generate
    for (genvar gi = 0; gi < N_CS; gi++) begin : g_region
      assign hit[gi] = ((bus.ADDR ^ BASE[gi*ADDR_W +: ADDR_W])
                        & MASK[gi*ADDR_W +: ADDR_W]) == '0;
      assign wait_tbl[gi] = WAIT[gi*4 +: 4];
    end
  endgenerate

  // Lowest index wins; the remap is applied after priority resolution.
  always_comb begin
    any_hit = |hit;
    winner  = '0;
    for (int i = N_CS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        winner = IDX_W'(i);
      end
    end
    if (bus.RMRD && any_hit && (winner == IDX_W'(RMRD_CS))) begin
      winner = IDX_W'(RMRD_ALT);
    end
    win_wait = wait_tbl[winner];
    win_cs_n = ~(N_CS'(1) << winner);
  end

  always_comb begin
    state_d   = state_q;
    cs_n_d    = cs_n_q;
    ready_d   = ready_q;
    nomatch_d = nomatch_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bus.AS) begin
          if (any_hit) begin
            cs_n_d  = win_cs_n;
            cnt_d   = win_wait;
            state_d = S_WAIT;
          end else begin
            ready_d   = 1'b1;
            nomatch_d = 1'b1;
            state_d   = S_DONE;
          end
        end
      end

      S_WAIT: begin
        if (!bus.AS) begin
          cs_n_d  = '1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          ready_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_DONE: begin
        if (!bus.AS) begin
          cs_n_d    = '1;
          ready_d   = 1'b0;
          nomatch_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        cs_n_d    = '1;
        ready_d   = 1'b0;
        nomatch_d = 1'b0;
        cnt_d     = '0;
        state_d   = S_IDLE;
      end
    endcase

    // BUSY tracks the registered state so it stays free of input-to-output paths.
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cs_n_q    <= '1;
      ready_q   <= 1'b0;
      nomatch_q <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cs_n_q    <= cs_n_d;
      ready_q   <= ready_d;
      nomatch_q <= nomatch_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.CS_N    = cs_n_q;
  assign bus.READY   = ready_q;
  assign bus.NOMATCH = nomatch_q;
  assign bus.BUSY    = busy_q;

endmodule
